// File: rtl/network_bf_in.sv
// -----------------------------------------------------------------------------
// network_bf_in
//
// Read-side routing network for the radix-2 NTT datapath. The two bank read
// words (q0, q1) are steered onto the butterfly upper/lower operands. The swap
// select travels with the read address, so it is delayed by the memory read
// latency together with the issue-valid flag. A pair counter tags each pair
// with its index inside the stage and marks the last pair of the stage.
//
// Ports:
//   clk        : clock, everything on the rising edge
//   rst        : synchronous active-high reset (clears everything)
//   q0, q1     : bank 0 / bank 1 read data, valid rd_lat cycles after issue
//   sel_b      : swap select issued with the read address (1 = swap)
//   rd_valid   : a read address pair is issued this cycle
//   en         : pipeline advance, 0 freezes the whole block
//   flush      : drop all in-flight pairs and clear the pair counter
//   bf_0_upper : butterfly upper operand (registered)
//   bf_0_lower : butterfly lower operand (registered)
//   bf_valid   : the operand registers hold a valid pair
//   bf_last    : the valid pair is the last one of the stage
//   pair_idx   : index of the pair on the outputs
// -----------------------------------------------------------------------------
module network_bf_in #(
    parameter int data_width = 14,
    parameter int rd_lat     = 1,
    parameter int cnt_width  = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [data_width-1:0] q0,
    input  logic [data_width-1:0] q1,
    input  logic                  sel_b,
    input  logic                  rd_valid,
    input  logic                  en,
    input  logic                  flush,
    output logic [data_width-1:0] bf_0_upper,
    output logic [data_width-1:0] bf_0_lower,
    output logic                  bf_valid,
    output logic                  bf_last,
    output logic [cnt_width-1:0]  pair_idx
);

    localparam logic [cnt_width-1:0] CNT_MAX = {cnt_width{1'b1}};

    // -------------------------------------------------------------------------
    // Select / valid delay lines, one generate stage per cycle of read latency.
    // Flush only kills the valid bits; a stale select behind a cleared valid
    // bit is never used.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < rd_lat; gi++) begin : g_dly
            logic sel_src;
            logic vld_src;
            logic sel_reg;
            logic vld_reg;

            if (gi == 0) begin : g_head
                assign sel_src = sel_b;
                assign vld_src = rd_valid;
            end else begin : g_body
                assign sel_src = g_dly[gi-1].sel_reg;
                assign vld_src = g_dly[gi-1].vld_reg;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    sel_reg <= 1'b0;
                    vld_reg <= 1'b0;
                end else if (flush) begin
                    vld_reg <= 1'b0;
                end else if (en) begin
                    sel_reg <= sel_src;
                    vld_reg <= vld_src;
                end
            end
        end
    endgenerate

    logic sel_d;
    logic vld_d;
    assign sel_d = g_dly[rd_lat-1].sel_reg;
    assign vld_d = g_dly[rd_lat-1].vld_reg;

    // -------------------------------------------------------------------------
    // Output register and pair counter.
    // -------------------------------------------------------------------------
    logic [data_width-1:0] upper_reg;
    logic [data_width-1:0] lower_reg;
    logic                  valid_reg;
    logic                  last_reg;
    logic [cnt_width-1:0]  idx_reg;
    logic [cnt_width-1:0]  cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            upper_reg <= '0;
            lower_reg <= '0;
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
            idx_reg   <= '0;
            cnt_reg   <= '0;
        end else if (flush) begin
            // Data and index hold; only the qualifiers and the counter clear.
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else if (en) begin
            if (vld_d) begin
                upper_reg <= sel_d ? q1 : q0;
                lower_reg <= sel_d ? q0 : q1;
                valid_reg <= 1'b1;
                last_reg  <= (cnt_reg == CNT_MAX);
                idx_reg   <= cnt_reg;
                cnt_reg   <= cnt_reg + 1'b1;   // wraps modulo 2**cnt_width
            end else begin
                // Bubble: qualifiers drop, data/index/counter hold.
                valid_reg <= 1'b0;
                last_reg  <= 1'b0;
            end
        end
    end

    assign bf_0_upper = upper_reg;
    assign bf_0_lower = lower_reg;
    assign bf_valid   = valid_reg;
    assign bf_last    = last_reg;
    assign pair_idx   = idx_reg;

endmodule

// File: tb/tb_network_bf_in.sv
// -----------------------------------------------------------------------------
// tb_network_bf_in
//
// Two instances share one stimulus stream: A uses rd_lat=1/cnt_width=7, B uses
// rd_lat=3/cnt_width=2. A small bank model per instance returns the data words
// rd_lat advancing cycles after issue. Expected pairs are pushed to a queue per
// instance at issue and popped when the instance shows a valid pair.
// -----------------------------------------------------------------------------
module tb_network_bf_in;

    localparam int DW    = 14;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    typedef struct {
        logic [DW-1:0] up;
        logic [DW-1:0] lo;
        int            idx;
        logic          last;
        int            arrive;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst      = 1'b1;
    logic          flush    = 1'b0;
    logic          en       = 1'b1;
    logic          rd_valid = 1'b0;
    logic          sel_b    = 1'b0;
    logic [DW-1:0] d0       = '0;
    logic [DW-1:0] d1       = '0;

    // Bank models: data written at issue appears rd_lat advancing edges later.
    logic [DW-1:0] pa0 [LAT_A];
    logic [DW-1:0] pa1 [LAT_A];
    logic [DW-1:0] pb0 [LAT_B];
    logic [DW-1:0] pb1 [LAT_B];

    always @(posedge clk) begin
        if (en) begin
            pa0[0] <= d0;
            pa1[0] <= d1;
            pb0[0] <= d0;
            pb1[0] <= d1;
            for (int i = 1; i < LAT_B; i++) begin
                pb0[i] <= pb0[i-1];
                pb1[i] <= pb1[i-1];
            end
        end
    end

    logic [DW-1:0] up_a, lo_a, up_b, lo_b;
    logic          v_a, l_a, v_b, l_b;
    logic [6:0]    idx_a;
    logic [1:0]    idx_b;

    network_bf_in #(.data_width(DW), .rd_lat(LAT_A), .cnt_width(7)) dut_a (
        .clk(clk), .rst(rst), .q0(pa0[LAT_A-1]), .q1(pa1[LAT_A-1]),
        .sel_b(sel_b), .rd_valid(rd_valid), .en(en), .flush(flush),
        .bf_0_upper(up_a), .bf_0_lower(lo_a), .bf_valid(v_a), .bf_last(l_a),
        .pair_idx(idx_a)
    );

    network_bf_in #(.data_width(DW), .rd_lat(LAT_B), .cnt_width(2)) dut_b (
        .clk(clk), .rst(rst), .q0(pb0[LAT_B-1]), .q1(pb1[LAT_B-1]),
        .sel_b(sel_b), .rd_valid(rd_valid), .en(en), .flush(flush),
        .bf_0_upper(up_b), .bf_0_lower(lo_b), .bf_valid(v_b), .bf_last(l_b),
        .pair_idx(idx_b)
    );

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t qa[$];
    exp_t qb[$];
    int   cnt_a = 0;
    int   cnt_b = 0;
    int   adv   = 0;     // number of advancing edges so far
    int   kind  = -1;    // last edge: 0 advance, 1 stall, 2 flush, 3 reset

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard push side: classify each edge and record issued reads.
    always @(posedge clk) begin
        exp_t e;
        if (rst)        kind = 3;
        else if (flush) kind = 2;
        else if (en)    kind = 0;
        else            kind = 1;
        if (kind == 0) adv++;
        if (kind >= 2) begin
            qa.delete();
            qb.delete();
            cnt_a = 0;
            cnt_b = 0;
        end else if (kind == 0 && rd_valid) begin
            e.up     = sel_b ? d1 : d0;
            e.lo     = sel_b ? d0 : d1;
            e.idx    = cnt_a;
            e.last   = (cnt_a == 127);
            e.arrive = adv + LAT_A;
            qa.push_back(e);
            cnt_a    = (cnt_a + 1) % 128;
            e.idx    = cnt_b;
            e.last   = (cnt_b == 3);
            e.arrive = adv + LAT_B;
            qb.push_back(e);
            cnt_b    = (cnt_b + 1) % 4;
        end
    end

    task automatic mon_side(input string s, input int k,
                            input logic [DW-1:0] up, input logic [DW-1:0] lo,
                            input logic v, input logic l, input int idx,
                            input bit have, input exp_t e,
                            input logic [DW-1:0] pup, input logic [DW-1:0] plo,
                            input logic pv, input logic pl, input int pidx,
                            output bit pop);
        pop = 1'b0;
        case (k)
            3: begin
                check({s, " rst upper"}, 32'(up), 32'd0);
                check({s, " rst lower"}, 32'(lo), 32'd0);
                check({s, " rst valid"}, 32'(v), 32'd0);
                check({s, " rst last"}, 32'(l), 32'd0);
                check({s, " rst idx"}, 32'(idx), 32'd0);
            end
            2: begin
                check({s, " flush valid"}, 32'(v), 32'd0);
                check({s, " flush last"}, 32'(l), 32'd0);
                check({s, " flush upper hold"}, 32'(up), 32'(pup));
                check({s, " flush lower hold"}, 32'(lo), 32'(plo));
            end
            1: begin
                check({s, " stall upper"}, 32'(up), 32'(pup));
                check({s, " stall lower"}, 32'(lo), 32'(plo));
                check({s, " stall valid"}, 32'(v), 32'(pv));
                check({s, " stall last"}, 32'(l), 32'(pl));
                check({s, " stall idx"}, 32'(idx), 32'(pidx));
            end
            0: begin
                if (v) begin
                    check({s, " pair expected"}, 32'(have), 32'd1);
                    if (have) begin
                        check({s, " arrival"}, 32'(adv), 32'(e.arrive));
                        check({s, " upper"}, 32'(up), 32'(e.up));
                        check({s, " lower"}, 32'(lo), 32'(e.lo));
                        check({s, " idx"}, 32'(idx), 32'(e.idx));
                        check({s, " last"}, 32'(l), 32'(e.last));
                        pop = 1'b1;
                    end
                end else begin
                    check({s, " bubble last"}, 32'(l), 32'd0);
                    check({s, " pair due"}, 32'(have && e.arrive <= adv), 32'd0);
                end
            end
            default: ;
        endcase
    endtask

    logic [DW-1:0] pup_a = '0, plo_a = '0, pup_b = '0, plo_b = '0;
    logic          pv_a = 1'b0, pl_a = 1'b0, pv_b = 1'b0, pl_b = 1'b0;
    int            pidx_a = 0, pidx_b = 0;

    // Scoreboard pop side, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t ea, eb;
        bit   pop_a, pop_b;
        ea = '{default: 0};
        eb = '{default: 0};
        if (qa.size() > 0) ea = qa[0];
        if (qb.size() > 0) eb = qb[0];
        mon_side("A", kind, up_a, lo_a, v_a, l_a, int'(idx_a), qa.size() > 0, ea,
                 pup_a, plo_a, pv_a, pl_a, pidx_a, pop_a);
        mon_side("B", kind, up_b, lo_b, v_b, l_b, int'(idx_b), qb.size() > 0, eb,
                 pup_b, plo_b, pv_b, pl_b, pidx_b, pop_b);
        if (pop_a) void'(qa.pop_front());
        if (pop_b) void'(qb.pop_front());
        if (kind >= 0) begin
            $display("cyc adv=%0d kind=%0d A: v=%0b up=%h lo=%h idx=%0d last=%0b | B: v=%0b up=%h lo=%h idx=%0d last=%0b",
                     adv, kind, v_a, up_a, lo_a, idx_a, l_a, v_b, up_b, lo_b, idx_b, l_b);
        end
        pup_a = up_a; plo_a = lo_a; pv_a = v_a; pl_a = l_a; pidx_a = int'(idx_a);
        pup_b = up_b; plo_b = lo_b; pv_b = v_b; pl_b = l_b; pidx_b = int'(idx_b);
    end

    task automatic step(input bit rv, input bit s, input int a, input int b);
        @(negedge clk);
        rd_valid = rv;
        sel_b    = s;
        d0       = DW'(a);
        d1       = DW'(b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        // Reset
        rst = 1'b1; en = 1'b1; flush = 1'b0;
        idle(2);
        @(negedge clk); rst = 1'b0;

        // Straight then swap
        step(1'b1, 1'b0, 'h0123, 'h0456);
        step(1'b1, 1'b1, 'h0AAA, 'h0555);
        idle(6);

        // Single read: latency check on both instances
        step(1'b1, 1'b0, 'h1111, 'h2222);
        idle(6);

        // Five back-to-back reads: B wraps 0,1,2,3,0
        for (int i = 0; i < 5; i++) step(1'b1, i[0], 'h100 + i, 'h200 + i);
        idle(6);

        // Stall with two pairs in flight
        step(1'b1, 1'b0, 'h0301, 'h0302);
        step(1'b1, 1'b1, 'h0303, 'h0304);
        @(negedge clk); rd_valid = 1'b0; en = 1'b0;
        idle(2);
        @(negedge clk); en = 1'b1;
        idle(6);

        // Flush mid-stage with a read issued in the same cycle
        step(1'b1, 1'b0, 'h0401, 'h0402);
        step(1'b1, 1'b1, 'h0403, 'h0404);
        step(1'b1, 1'b0, 'h0405, 'h0406);
        flush = 1'b1;
        @(negedge clk); flush = 1'b0; rd_valid = 1'b0;
        idle(5);
        step(1'b1, 1'b1, 'h0501, 'h0502);
        idle(6);

        // Reset and flush together during traffic, then bubbles
        step(1'b1, 1'b0, 'h0601, 'h0602);
        step(1'b1, 1'b1, 'h0603, 'h0604);
        step(1'b1, 1'b0, 'h0605, 'h0606);
        rst = 1'b1; flush = 1'b1;
        @(negedge clk); rst = 1'b0; flush = 1'b0; rd_valid = 1'b0;
        step(1'b1, 1'b0, 'h0701, 'h0702);
        step(1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b1, 'h0703, 'h0704);
        idle(6);

        // Mixed traffic with stalls and the odd flush
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            en       = ($urandom_range(0, 4) != 0);
            flush    = ($urandom_range(0, 29) == 0);
            rd_valid = $urandom_range(0, 1);
            sel_b    = $urandom_range(0, 1);
            d0       = DW'($urandom_range(0, 16383));
            d1       = DW'($urandom_range(0, 16383));
        end
        @(negedge clk); en = 1'b1; flush = 1'b0; rd_valid = 1'b0;

        // Drain, bounded
        begin
            int budget = 20;
            while ((qa.size() > 0 || qb.size() > 0) && budget > 0) begin
                idle(1);
                budget--;
            end
            check("drain queues empty", 32'(qa.size() + qb.size()), 32'd0);
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/network_bf_in.md
Name: network_bf_in

Overview:
Read-side routing network for the radix-2 NTT datapath. It takes the two memory-bank read words (q0, q1) and steers them onto the butterfly's upper and lower inputs, using a swap select issued together with the read address. The select and a valid flag are delayed to line up with the memory read latency. A pair counter tags the butterfly inputs with an index and flags the last pair of each stage. It is the inverse counterpart of the butterfly-output-to-memory network.

Parameters:
data_width, 14, width of a coefficient word.
rd_lat, 1, memory read latency in cycles from address issue to q0/q1 valid; legal range 1..8.
cnt_width, 7, pair counter width; pairs per stage = 2**cnt_width.

Ports:
clk  input  1  clock, all logic on rising edge.
rst  input  1  synchronous reset, active-high.
q0  input  data_width  bank 0 read data; valid rd_lat cycles after address issue.
q1  input  data_width  bank 1 read data; same timing as q0.
sel_b  input  1  swap select issued with the read address; 0 = straight, 1 = swap.
rd_valid  input  1  high in the cycle a read address pair is issued.
en  input  1  pipeline advance; 0 stalls the whole block.
flush  input  1  synchronous drop of all in-flight pairs and counter clear.
bf_0_upper  output  data_width  butterfly upper operand (registered).
bf_0_lower  output  data_width  butterfly lower operand (registered).
bf_valid  output  1  bf_0_upper/bf_0_lower hold a valid pair this cycle.
bf_last  output  1  qualifies bf_valid; the pair is the last of the stage.
pair_idx  output  cnt_width  index of the pair currently on the outputs.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: all outputs 0; sel/valid delay lines 0; pair counter 0.
- Delay lines: sel_b and rd_valid each pass through an rd_lat-deep shift register that advances only when en=1. The tap outputs are sel_d and vld_d.
- Output register, when en=1 and vld_d=1:
  - sel_d=0: bf_0_upper<=q0, bf_0_lower<=q1.
  - sel_d=1: bf_0_upper<=q1, bf_0_lower<=q0.
  - bf_valid<=1; pair_idx<=cnt; bf_last<=(cnt==2**cnt_width-1).
  - cnt<=cnt+1, wrapping from 2**cnt_width-1 to 0.
- When en=1 and vld_d=0: bf_valid<=0, bf_last<=0; data outputs and pair_idx hold their previous values; cnt holds.
- Latency: rd_valid at cycle t (en held 1) gives bf_valid at t+rd_lat+1. Throughput is one pair per cycle.
- Stall (en=0):
  - Delay lines, output registers and counter all hold; bf_valid keeps its value.
  - Memory is stalled by the same en, so q0/q1 stay stable. No input is sampled during a stall.
- Flush (flush=1), next cycle:
  - Delay-line valid bits=0, bf_valid=0, bf_last=0, cnt=0. Data outputs hold.
  - Flush takes priority over en and over rd_valid in the same cycle; that issued read is dropped.
- Simultaneous rst and flush: rst wins (all zero).
- Reset mid-stream discards all in-flight pairs; the first rd_valid after rst deasserts produces pair_idx=0.
- rd_valid gaps need no special handling: bubbles propagate as bf_valid=0, and the counter does not advance on bubbles.
- Widths: no arithmetic on data, pure routing; the counter is modulo 2**cnt_width.

Test Plan:
- Straight/swap, rd_lat=1, en=1: rd_valid=1 at t with sel_b=0, then t+1 with sel_b=1; q0=0x0123,q1=0x0456 at t+1 and q0=0x0AAA,q1=0x0555 at t+2 -> t+2: upper=0x0123, lower=0x0456, valid=1, pair_idx=0; t+3: upper=0x0555, lower=0x0AAA, pair_idx=1.
- Latency sweep rd_lat=3: single rd_valid at t -> bf_valid exactly at t+4 only; q sampled at t+3.
- Stage wrap, cnt_width=2: 5 back-to-back reads -> pair_idx 0,1,2,3,0; bf_last=1 only on pair_idx=3.
- Stall: en=0 for 3 cycles while 2 pairs are in flight -> outputs frozen; after en=1 the pairs emerge in order with latency extended by 3 and no loss or duplication.
- Flush mid-stage: 2 pairs in flight plus flush=1 with rd_valid=1 -> no further bf_valid; next read gives pair_idx=0.
- Reset priority: rst=1 and flush=1 together during traffic -> all outputs 0 the next cycle; bubbles (rd_valid 1,0,1) give bf_valid 1,0,1 with pair_idx 0,hold,1.
